// File: rtl/buffered_spi_master.sv
// SPI mode-0 master with a transmit FIFO; one DATA_WIDTH word per cs-low frame, MSB first.
// Each received word is presented on rx_data with a one-cycle rx_valid as cs rises.
module buffered_spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int TX_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  cs,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);
  localparam int AW   = $clog2(TX_DEPTH);
  localparam int CW   = AW + 1;
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD} state_t;
  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_mem [TX_DEPTH];
  logic [AW-1:0]         r_wr, r_rd;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic [DIVW-1:0]       r_div;
  logic [BW-1:0]         r_bit;
  logic                  r_rx_valid, r_en;

  logic w_empty, w_full, w_push, w_div_done, w_bits_done;
  logic w_cs, w_sck, w_pop, w_sample, w_shift, w_last, w_enter_hi;

  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == CW'(TX_DEPTH));
  assign w_push      = tx_valid & tx_ready;
  assign w_div_done  = (r_div == DIVW'(CLK_DIV - 1));
  assign w_bits_done = (r_bit == BW'(DATA_WIDTH));
  assign w_enter_hi  = (w_next == SHIFT_HI) && (r_state != SHIFT_HI);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (!w_empty)  w_next = SETUP;
      SETUP:    if (w_div_done) w_next = SHIFT_HI;
      SHIFT_HI: if (w_div_done) w_next = SHIFT_LO;
      SHIFT_LO: if (w_div_done) w_next = w_bits_done ? HOLD : SHIFT_HI;
      HOLD:     if (w_div_done) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cs     = 1'b1;
    w_sck    = 1'b0;
    w_pop    = 1'b0;
    w_sample = 1'b0;
    w_shift  = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE:  w_pop = !w_empty;
      SETUP: w_cs  = 1'b0;
      SHIFT_HI: begin
        w_cs     = 1'b0;
        w_sck    = 1'b1;
        w_sample = (r_div == '0);
        // r_bit already counts this rising edge, so the last bit leaves mosi alone
        w_shift  = w_div_done && !w_bits_done;
      end
      SHIFT_LO: begin
        w_cs   = 1'b0;
        w_last = w_div_done && w_bits_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_rx_valid <= 1'b0;
      r_en       <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase

      if (r_state == IDLE || w_next != r_state) r_div <= '0;
      else                                      r_div <= r_div + DIVW'(1);

      if (w_pop) begin
        r_tx  <= r_mem[r_rd];
        r_bit <= '0;
      end else begin
        if (w_shift)    r_tx  <= {r_tx[DATA_WIDTH-2:0], 1'b0};
        if (w_enter_hi) r_bit <= r_bit + BW'(1);
      end

      if (w_sample) r_rx <= {r_rx[DATA_WIDTH-2:0], miso};
      r_rx_valid <= w_last;
      if (w_last) r_rx_data <= r_rx;
    end
  end

  assign tx_ready = r_en & ~w_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state != IDLE) | ~w_empty;
  assign cs       = w_cs;
  assign sck      = w_sck;
  assign mosi     = r_tx[DATA_WIDTH-1];
endmodule

// File: tb/tb_buffered_spi_master.sv
// Bench for buffered_spi_master: an 8-bit/CLK_DIV=2 instance driven by scenario tasks and watched by
// a frame monitor, plus a 16-bit/CLK_DIV=1 instance for the wide loopback case.
module tb_buffered_spi_master;
  localparam int DW = 8, CDIV = 2, DEPTH = 16;
  localparam int DW2 = 16, CDIV2 = 1;
  localparam int LOW_EXP  = CDIV * (2 * DW + 1);
  localparam int LOW_EXP2 = CDIV2 * (2 * DW2 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, rx_valid, busy, cs, sck, mosi, miso;
  logic [DW-1:0] rx_data;
  logic          miso_inv = 1'b0, miso_force = 1'b0, miso_val = 1'b0;
  assign miso = miso_force ? miso_val : (mosi ^ miso_inv);

  logic [DW2-1:0] tx_data2 = '0, rx_data2;
  logic           tx_valid2 = 1'b0;
  logic           tx_ready2, rx_valid2, busy2, cs2, sck2, mosi2, miso2;
  assign miso2 = mosi2;

  buffered_spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CDIV), .TX_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso));

  buffered_spi_master #(.DATA_WIDTH(DW2), .CLK_DIV(CDIV2), .TX_DEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2), .cs(cs2), .sck(sck2), .mosi(mosi2), .miso(miso2));

  int tests = 0, fails = 0;

  // Frame monitor: records each completed frame as seen on the pins
  typedef struct { int low; int edges; logic [DW-1:0] word; int gap; } frame_t;
  frame_t        frame_q[$];
  logic [DW-1:0] rx_q[$];
  int            cur_low = 0, cur_edges = 0, cur_gap = 0, gap_cnt = 999;
  int            mosi_viol = 0, hold_viol = 0, dbl_viol = 0;
  logic [DW-1:0] cur_word = '0, last_rx = '0;
  logic          in_frame = 1'b0, p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_rxv = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      in_frame = 1'b0;
      gap_cnt  = 999;
      last_rx  = rx_data;
    end else begin
      if (p_cs && !cs) begin
        in_frame = 1'b1; cur_low = 0; cur_edges = 0; cur_word = '0; cur_gap = gap_cnt;
      end
      if (in_frame && !cs) begin
        cur_low++;
        if (sck && !p_sck) begin cur_edges++; cur_word = {cur_word[DW-2:0], mosi}; end
      end
      if (!p_cs && cs && in_frame) begin
        frame_q.push_back('{cur_low, cur_edges, cur_word, cur_gap});
        in_frame = 1'b0;
        gap_cnt  = 0;
      end
      if (cs) gap_cnt++;
      if (mosi !== p_mosi && !(cs === 1'b0 && sck === 1'b0)) mosi_viol++;
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        if (p_rxv) dbl_viol++;
      end else if (rx_data !== last_rx) hold_viol++;
      last_rx = rx_data;
    end
    p_cs = cs; p_sck = sck; p_mosi = mosi; p_rxv = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d, output bit acc);
    tx_data = d; tx_valid = 1'b1; acc = tx_ready;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k = 0;
    while (frame_q.size() < n && k < budget) begin @(negedge clk); k++; end
    tick(2);
    ok = (frame_q.size() >= n);
  endtask

  task automatic clear_q();
    frame_q.delete(); rx_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    tests++; if (cs !== 1'b1)       begin fails++; $display("FAIL reset_cs: got %b expected 1", cs); end
    tests++; if (sck !== 1'b0)      begin fails++; $display("FAIL reset_sck: got %b expected 0", sck); end
    tests++; if (mosi !== 1'b0)     begin fails++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    tests++; if (rx_data !== '0)    begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
    reset = 1'b1;
    tick(1);
    tests++; if (tx_ready !== 1'b1)  begin fails++; $display("FAIL post_reset_tx_ready: got %b expected 1", tx_ready); end
    tests++; if (tx_ready2 !== 1'b1) begin fails++; $display("FAIL post_reset_tx_ready2: got %b expected 1", tx_ready2); end
  endtask

  task automatic test_single();
    bit acc, ok;
    clear_q();
    push(8'hA5, acc);
    wait_frames(1, 200, ok);
    tests++; if (!ok || !acc) begin fails++; $display("FAIL single_frame: got %0d frames expected 1", frame_q.size()); end
    else begin
      tests++; if (frame_q[0].low != LOW_EXP) begin fails++; $display("FAIL single_cs_low: got %0d expected %0d", frame_q[0].low, LOW_EXP); end
      tests++; if (frame_q[0].edges != DW)    begin fails++; $display("FAIL single_sck_pulses: got %0d expected %0d", frame_q[0].edges, DW); end
      tests++; if (frame_q[0].word !== 8'hA5) begin fails++; $display("FAIL single_mosi: got %h expected a5", frame_q[0].word); end
      tests++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
        fails++; $display("FAIL single_rx: got %0d pulses first %h expected 1 pulse a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [3] = '{8'h3C, 8'hFF, 8'h00};
    bit acc, ok;
    clear_q();
    for (int i = 0; i < 3; i++) push(exp[i], acc);
    wait_frames(3, 400, ok);
    tests++; if (!ok || rx_q.size() != 3) begin
      fails++; $display("FAIL b2b_count: got %0d frames %0d rx expected 3 3", frame_q.size(), rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (frame_q[i].word !== exp[i]) begin fails++; $display("FAIL b2b_mosi%0d: got %h expected %h", i, frame_q[i].word, exp[i]); end
        tests++; if (rx_q[i] !== exp[i])         begin fails++; $display("FAIL b2b_rx%0d: got %h expected %h", i, rx_q[i], exp[i]); end
        tests++; if (frame_q[i].low != LOW_EXP)  begin fails++; $display("FAIL b2b_low%0d: got %0d expected %0d", i, frame_q[i].low, LOW_EXP); end
        if (i > 0) begin
          tests++; if (frame_q[i].gap != CDIV + 1) begin fails++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, frame_q[i].gap, CDIV + 1); end
        end
      end
    end
  endtask

  task automatic test_miso_const();
    bit acc, ok;
    clear_q();
    miso_force = 1'b1; miso_val = 1'b1;
    push(8'h00, acc);
    wait_frames(1, 200, ok);
    miso_force = 1'b0;
    tests++; if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'hFF || frame_q[0].word !== 8'h00) begin
      fails++; $display("FAIL miso_const: got rx %h mosi %h expected rx ff mosi 00",
                        (rx_q.size() > 0) ? rx_q[0] : 8'hxx, (frame_q.size() > 0) ? frame_q[0].word : 8'hxx);
    end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d;
    bit acc, ok;
    int k = 0;
    clear_q();
    push(8'h11, acc);
    exp_q.push_back(8'h11);
    while (cs && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < DEPTH; i++) begin
      d = DW'($urandom);
      push(d, acc);
      tests++; if (!acc) begin fails++; $display("FAIL full_accept%0d: got tx_ready 0 expected 1", i); end
      else exp_q.push_back(d);
    end
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL full_tx_ready: got %b expected 0", tx_ready); end
    push(8'hEE, acc);
    tests++; if (acc) begin fails++; $display("FAIL full_drop: got accepted expected dropped"); end
    wait_frames(exp_q.size(), 2000, ok);
    tests++; if (!ok || frame_q.size() != exp_q.size() || rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL full_count: got %0d frames expected %0d", frame_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++; if (frame_q[i].word !== exp_q[i] || rx_q[i] !== exp_q[i]) begin
          fails++; $display("FAIL full_word%0d: got mosi %h rx %h expected %h", i, frame_q[i].word, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d;
    bit acc, ok;
    clear_q();
    miso_inv = 1'($urandom_range(0, 1));
    for (int i = 0; i < 12; i++) begin
      tick($urandom_range(0, 40));
      d = DW'($urandom);
      push(d, acc);
      if (acc) exp_q.push_back(d);
    end
    wait_frames(exp_q.size(), 1500, ok);
    tests++; if (!ok || frame_q.size() != exp_q.size() || rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rand_count: got %0d frames %0d rx expected %0d", frame_q.size(), rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++; if (frame_q[i].word !== exp_q[i] || rx_q[i] !== (exp_q[i] ^ {DW{miso_inv}})) begin
          fails++; $display("FAIL rand_word%0d: got mosi %h rx %h expected mosi %h rx %h",
                            i, frame_q[i].word, rx_q[i], exp_q[i], exp_q[i] ^ {DW{miso_inv}});
        end
        tests++; if (frame_q[i].low != LOW_EXP || frame_q[i].gap < CDIV + 1) begin
          fails++; $display("FAIL rand_timing%0d: got low %0d gap %0d expected low %0d gap >= %0d",
                            i, frame_q[i].low, frame_q[i].gap, LOW_EXP, CDIV + 1);
        end
      end
    end
    miso_inv = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit acc;
    int k = 0;
    clear_q();
    push(8'h5A, acc); push(8'hC3, acc); push(8'h96, acc);
    while (!(in_frame && cur_edges == 4) && k < 200) begin @(negedge clk); k++; end
    tests++; if (k >= 200) begin fails++; $display("FAIL abort_reach_bit4: got timeout expected 4th sck edge"); end
    reset = 1'b0;
    tick(1);
    tests++; if (cs !== 1'b1 || sck !== 1'b0) begin fails++; $display("FAIL abort_pins: got cs %b sck %b expected cs 1 sck 0", cs, sck); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL abort_rx_valid: got %b expected 0", rx_valid); end
    tick(2);
    reset = 1'b1;
    tick(300);
    tests++; if (frame_q.size() != 0 || rx_q.size() != 0) begin
      fails++; $display("FAIL abort_no_frames: got %0d frames %0d rx expected 0 0", frame_q.size(), rx_q.size());
    end
    tests++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      fails++; $display("FAIL abort_idle: got busy %b tx_ready %b expected 0 1", busy, tx_ready);
    end
  endtask

  task automatic test_wide();
    logic [DW2-1:0] w, word, rxw;
    int  low, k;
    bit  ps, got_rx;
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? 16'h8001 : DW2'($urandom);
      tx_data2 = w; tx_valid2 = 1'b1;
      @(negedge clk);
      tx_valid2 = 1'b0;
      k = 0;
      while (cs2 && k < 100) begin @(negedge clk); k++; end
      low = 0; word = '0; ps = 1'b0; k = 0;
      while (!cs2 && k < 200) begin
        low++;
        if (sck2 && !ps) word = {word[DW2-2:0], mosi2};
        ps = sck2;
        @(negedge clk); k++;
      end
      got_rx = rx_valid2; rxw = rx_data2;
      tests++; if (low != LOW_EXP2) begin fails++; $display("FAIL wide_low%0d: got %0d expected %0d", n, low, LOW_EXP2); end
      tests++; if (word !== w)      begin fails++; $display("FAIL wide_mosi%0d: got %h expected %h", n, word, w); end
      tests++; if (!got_rx || rxw !== w) begin fails++; $display("FAIL wide_rx%0d: got valid %b data %h expected 1 %h", n, got_rx, rxw, w); end
      tick(3);
    end
  endtask

  task automatic test_protocol();
    tests++; if (mosi_viol != 0) begin fails++; $display("FAIL mosi_stable: got %0d changes outside sck low expected 0", mosi_viol); end
    tests++; if (hold_viol != 0) begin fails++; $display("FAIL rx_hold: got %0d rx_data changes without rx_valid expected 0", hold_viol); end
    tests++; if (dbl_viol != 0)  begin fails++; $display("FAIL rx_pulse: got %0d multi-cycle rx_valid expected 0", dbl_viol); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_miso_const();
    test_fifo_full();
    test_random();
    test_reset_midframe();
    test_wide();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/buffered_spi_master.md
BUFFERED_SPI_MASTER -- requirements
Module: buffered_spi_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving bits per transfer; it must be a multiple of 8.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving clk cycles per SCK half-period; it must be at least 1.
REQ-003 The block SHALL have parameter TX_DEPTH, default 16, giving transmit FIFO entries; it must be a power of 2 and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port tx_data, input, DATA_WIDTH bits: word to transmit.
REQ-007 The block SHALL have port tx_valid, input, 1 bit: tx_data is offered.
REQ-008 The block SHALL have port tx_ready, output, 1 bit: FIFO not full; the word is accepted when tx_valid & tx_ready.
REQ-009 The block SHALL have port rx_data, output, DATA_WIDTH bits: word captured from miso.
REQ-010 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking rx_data valid.
REQ-011 The block SHALL have port busy, output, 1 bit: high when a frame is in progress or the FIFO is non-empty.
REQ-012 The block SHALL have port cs, output, 1 bit: active-low chip select.
REQ-013 The block SHALL have port sck, output, 1 bit: SPI clock.
REQ-014 The block SHALL have port mosi, output, 1 bit: serial data out.
REQ-015 The block SHALL have port miso, input, 1 bit: serial data in, assumed synchronous to the block's own sck.

Function
REQ-016 The block SHALL use SPI mode 0 (CPOL=0, CPHA=0), MSB first, with exactly one word per cs-low frame.
REQ-017 The block SHALL buffer accepted words in a TX_DEPTH-entry FIFO and transmit them in acceptance order.
REQ-018 A write attempted while the FIFO is full SHALL be ignored: tx_ready=0 and FIFO contents unchanged.
REQ-019 The block SHALL have no write-to-pop bypass: a word written into an empty FIFO at cycle N is popped no earlier than cycle N+1.
REQ-020 The state machine SHALL use states IDLE, SETUP, SHIFT_HI, SHIFT_LO and HOLD.
REQ-021 IDLE: on the cycle the FIFO is non-empty, the block SHALL pop a word into the shift register; on the next cycle cs=0, mosi=MSB, and the state is SETUP.
REQ-022 SETUP SHALL last CLK_DIV cycles with sck=0, then enter SHIFT_HI.
REQ-023 SHIFT_HI SHALL hold sck=1 for CLK_DIV cycles and sample miso into the rx shift register on the first cycle.
REQ-024 SHIFT_LO SHALL hold sck=0 for CLK_DIV cycles; on entry, mosi SHALL present the next bit unless the last bit has been sent.
REQ-025 A bit counter SHALL count DATA_WIDTH rising sck edges; after the DATA_WIDTH-th SHIFT_LO completes, the block SHALL enter HOLD.
REQ-026 On entry to HOLD, cs SHALL rise, rx_data SHALL update, and rx_valid SHALL pulse high for exactly 1 cycle.
REQ-027 HOLD SHALL keep cs=1 and sck=0 for CLK_DIV cycles, then go to IDLE; the minimum cs-high gap between frames is CLK_DIV+1 cycles.
REQ-028 cs-low duration per frame SHALL be exactly CLK_DIV*(2*DATA_WIDTH+1) cycles.
REQ-029 rx_data SHALL hold its value until the next rx_valid pulse.
REQ-030 FIFO push and pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-031 mosi SHALL change only while sck=0 and cs=0, or on the cycle cs falls.

Reset
REQ-032 While reset=0 at a clk edge, the block SHALL set: state IDLE, FIFO empty, cs=1, sck=0, mosi=0, rx_valid=0, rx_data=0, busy=0, tx_ready=0.
REQ-033 tx_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-034 Reset asserted mid-frame SHALL abort the frame: cs=1 and sck=0 on the next cycle, with no rx_valid pulse and queued words discarded.

Verification
REQ-035 Scenario: DATA_WIDTH=8, CLK_DIV=2, write 0xA5 with miso looped to mosi -> cs low 34 cycles, 8 sck pulses, mosi 1,0,1,0,0,1,0,1, rx_valid once with rx_data=0xA5.
REQ-036 Scenario: write 0x3C, 0xFF, 0x00 back-to-back -> three frames in order, each separated by a cs-high gap of 3 cycles (CLK_DIV=2), three rx_valid pulses.
REQ-037 Scenario: write 17 words with TX_DEPTH=16 while the block is stalled in the first frame -> tx_ready=0 when full, 17th word dropped only if the FIFO is still full at the write, no corruption of the other words.
REQ-038 Scenario: miso driven constant 1 while sending 0x00 -> rx_data=0xFF.
REQ-039 Scenario: reset=0 during bit 4 of a frame with 2 words queued -> cs=1 and sck=0 the next cycle, no rx_valid, busy=0, and no further frames.
REQ-040 Scenario: DATA_WIDTH=16, CLK_DIV=1, send 0x8001 in loopback -> cs low 33 cycles, rx_data=0x8001.
